pool2x2_stream: RTL and testbench

- Parametrised streaming 2x2, stride-2 pooling stage, placed between a convolution stage and the flatten/dense stage.
- Accepts one signed pixel per cycle in row-major raster order, qualified by a valid strobe.
- Emits one pooled value per 2x2 window in either max or average mode.
- Uses a half-width line buffer instead of two full row buffers; it also handles stalls, frame boundaries and a synchronous restart.

---
 rtl/pool2x2_stream_if.sv | 23 ++
 rtl/pool2x2_stream.sv | 121 ++++++++++++
 tb/tb_pool2x2_stream.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool2x2_stream_if.sv
// Stream bundle for the 2x2 pooling stage: pixel input side plus pooled output side.
// The pooling stage attaches through the slave modport; the pixel source uses master.
interface pool2x2_stream_if #(
    parameter int W = 9
);
    logic         mode;
    logic [W-1:0] din;
    logic         din_valid;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         frame_done;
    logic         busy;

    modport master (
        output mode, din, din_valid,
        input  dout, dout_valid, frame_done, busy
    );

    modport slave (
        input  mode, din, din_valid,
        output dout, dout_valid, frame_done, busy
    );
endinterface

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 stride-2 max/average pooling over a raster-order pixel stream,
// using a half-width line buffer of horizontal pair results.
module pool2x2_stream #(
    parameter int W     = 9,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    pool2x2_stream_if.slave bus
);
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int LBN = IMG_W / 2;
    localparam int LW  = (LBN > 1) ? $clog2(LBN) : 1;

    logic        [CW-1:0] r_col;
    logic        [RW-1:0] r_row;
    logic                 r_mode;
    logic                 r_busy;
    logic signed [W-1:0]  r_h;
    logic signed [W:0]    r_lb [0:(2**LW)-1];
    logic signed [W-1:0]  r_dout;
    logic                 r_dout_valid;
    logic                 r_frame_done;

    logic                 w_accept;
    logic signed [W-1:0]  w_din;
    logic                 w_col_last;
    logic                 w_row_last;
    logic        [LW-1:0] w_idx;
    logic signed [W:0]    w_stored;
    logic signed [W:0]    w_pair;
    logic signed [W+1:0]  w_vsum;
    logic signed [W-1:0]  w_res;

    assign w_accept   = bus.din_valid & ~clear;
    assign w_din      = bus.din;
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));
    assign w_idx      = LW'(r_col >> 1);
    assign w_stored   = r_lb[w_idx];

    // The pair and vertical results use the latched mode, which is already valid
    // by the first odd column because it is captured at pixel (0,0).
    always_comb begin
        w_pair = '0;
        w_vsum = '0;
        w_res  = '0;
        if (r_mode)
            w_pair = {r_h[W-1], r_h} + {w_din[W-1], w_din};
        else
            w_pair = (r_h > w_din) ? {r_h[W-1], r_h} : {w_din[W-1], w_din};
        w_vsum = {w_stored[W], w_stored} + {w_pair[W], w_pair};
        if (r_mode)
            w_res = W'(w_vsum >>> 2);
        else
            w_res = (w_stored > w_pair) ? W'(w_stored) : W'(w_pair);
    end

    // Line buffer has no reset; every entry is rewritten on an even row before it is read.
    always_ff @(posedge clk) begin
        if (w_accept && r_col[0] && !r_row[0])
            r_lb[w_idx] <= w_pair;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_mode       <= 1'b0;
            r_busy       <= 1'b0;
            r_h          <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (clear) begin
            r_col        <= '0;
            r_row        <= '0;
            r_mode       <= 1'b0;
            r_busy       <= 1'b0;
            r_h          <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            r_frame_done <= 1'b0;
            if (bus.din_valid) begin
                if (r_col == '0 && r_row == '0) begin
                    r_mode <= bus.mode;
                    r_busy <= 1'b1;
                end
                if (!r_col[0])
                    r_h <= w_din;
                if (r_col[0] && r_row[0]) begin
                    r_dout       <= w_res;
                    r_dout_valid <= 1'b1;
                    r_frame_done <= w_col_last && w_row_last;
                end
                if (w_col_last) begin
                    r_col <= '0;
                    if (w_row_last) begin
                        r_row  <= '0;
                        r_busy <= 1'b0;
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_pool2x2_stream.sv
// Scoreboard bench for pool2x2_stream: a 4x4 instance for directed windows and a
// 28x28 instance for back-to-back random frames against a window reference model.
module tb_pool2x2_stream;
    localparam int W      = 9;
    localparam int PERIOD = 10;

    typedef struct {
        int     value;
        bit     fd;
        longint due;
    } expT;

    logic clk;
    logic rst;
    logic clear;

    int   nCompared;
    int   nMismatched;
    int   fd4Count;
    int   strobe28Count;
    int   fd28Count;
    expT  q4[$];
    expT  q28[$];
    int   ramp[16];
    int   ramp16[16];
    int   negFrame[16];
    int   pix28[28][28];

    pool2x2_stream_if #(.W(W)) bus4 ();
    pool2x2_stream_if #(.W(W)) bus28 ();

    pool2x2_stream #(.W(W), .IMG_W(4), .IMG_H(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus4)
    );

    pool2x2_stream #(.W(W), .IMG_W(28), .IMG_H(28)) dut28 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus28)
    );

    initial begin
        clk = 1'b0;
        forever #(PERIOD / 2) clk = ~clk;
    end

    initial begin
        #(PERIOD * 20000);
        $display("[TB] FAIL watchdog: simulation still running at t=%0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic afterEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int v, input bit md, input bit hasExp, input int expVal, input bit expFd);
        expT e;
        @(negedge clk);
        clear          = 1'b0;
        bus4.din       = W'(v);
        bus4.din_valid = 1'b1;
        bus4.mode      = md;
        if (hasExp) begin
            e.value = expVal;
            e.fd    = expFd;
            e.due   = $time + PERIOD;
            q4.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            clear          = 1'b0;
            bus4.din_valid = 1'b0;
            bus4.din       = W'($urandom);
        end
    endtask

    task automatic runFrame4(input int px[16], input int ex[4], input bit md, input bit stall, input bit flip);
        int r;
        int c;
        bit m;
        for (int i = 0; i < 16; i++) begin
            if (stall) idle(int'($urandom_range(0, 3)));
            r = i / 4;
            c = i % 4;
            m = (flip && i > 3) ? ~md : md;
            if (r % 2 == 1 && c % 2 == 1)
                applyStimulus(px[i], m, 1'b1, ex[(r / 2) * 2 + c / 2], i == 15);
            else
                applyStimulus(px[i], m, 1'b0, 0, 1'b0);
            if (i == 0) begin
                afterEdge();
                checkOutput("busy after first pixel", int'(bus4.busy), 1);
            end
        end
        afterEdge();
        checkOutput("busy after last pixel", int'(bus4.busy), 0);
    endtask

    task automatic runPartial4();
        for (int i = 0; i < 7; i++)
            applyStimulus(ramp[i], 1'b0, i == 5, 5, 1'b0);
    endtask

    function automatic int refWindow(input int a, input int b, input int c, input int d, input bit avg);
        int s;
        int mx;
        if (avg) begin
            s = a + b + c + d;
            return (s >= 0) ? s / 4 : -((-s + 3) / 4);
        end
        mx = a;
        if (b > mx) mx = b;
        if (c > mx) mx = c;
        if (d > mx) mx = d;
        return mx;
    endfunction

    // Each monitor pops one expectation per strobe and flags strobes that are early, late or missing.
    always @(negedge clk) begin : monitor4
        expT e;
        if (bus4.dout_valid === 1'b1) begin
            if (bus4.frame_done === 1'b1) fd4Count++;
            if (q4.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL dut4 unexpected strobe: got dout=%0d, required no strobe (t=%0t)", $signed(bus4.dout), $time);
            end else begin
                e = q4.pop_front();
                checkOutput("dut4 dout", int'($signed(bus4.dout)), e.value);
                checkOutput("dut4 frame_done", int'(bus4.frame_done), int'(e.fd));
                checkOutput("dut4 strobe offset", int'($time - e.due), 0);
            end
        end else begin
            checkOutput("dut4 frame_done without strobe", int'(bus4.frame_done === 1'b1), 0);
            if (q4.size() > 0 && q4[0].due <= $time) begin
                e = q4.pop_front();
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL dut4 missing strobe: got none, required dout=%0d (t=%0t)", e.value, $time);
            end
        end
    end

    always @(negedge clk) begin : monitor28
        expT e;
        if (bus28.dout_valid === 1'b1) begin
            strobe28Count++;
            if (bus28.frame_done === 1'b1) fd28Count++;
            if (q28.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL dut28 unexpected strobe: got dout=%0d, required no strobe (t=%0t)", $signed(bus28.dout), $time);
            end else begin
                e = q28.pop_front();
                checkOutput("dut28 dout", int'($signed(bus28.dout)), e.value);
                checkOutput("dut28 frame_done", int'(bus28.frame_done), int'(e.fd));
                checkOutput("dut28 strobe offset", int'($time - e.due), 0);
            end
        end else if (q28.size() > 0 && q28[0].due <= $time) begin
            e = q28.pop_front();
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL dut28 missing strobe: got none, required dout=%0d (t=%0t)", e.value, $time);
        end
    end

    initial begin
        int   ex[4];
        int   wv;
        expT  e;
        logic signed [W-1:0] s;

        void'($urandom(32'd20240611));
        for (int i = 0; i < 16; i++) begin
            ramp[i]     = i;
            ramp16[i]   = i + 16;
            negFrame[i] = 0;
        end
        negFrame[0] = -1;
        negFrame[1] = -2;
        negFrame[4] = -3;
        negFrame[5] = -4;

        clear           = 1'b0;
        bus4.din        = '0;
        bus4.din_valid  = 1'b0;
        bus4.mode       = 1'b0;
        bus28.din       = '0;
        bus28.din_valid = 1'b0;
        bus28.mode      = 1'b0;
        rst             = 1'b1;
        #1 rst = 1'b0;
        #2;
        checkOutput("reset dout", int'(bus4.dout), 0);
        checkOutput("reset dout_valid", int'(bus4.dout_valid), 0);
        checkOutput("reset frame_done", int'(bus4.frame_done), 0);
        checkOutput("reset busy", int'(bus4.busy), 0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        $display("[TB] max ramp");
        ex = '{5, 7, 13, 15};
        runFrame4(ramp, ex, 1'b0, 1'b0, 1'b0);

        $display("[TB] average ramp");
        ex = '{2, 4, 10, 12};
        runFrame4(ramp, ex, 1'b1, 1'b0, 1'b0);

        $display("[TB] negative window, max then average");
        ex = '{-1, 0, 0, 0};
        runFrame4(negFrame, ex, 1'b0, 1'b0, 1'b0);
        ex = '{-3, 0, 0, 0};
        runFrame4(negFrame, ex, 1'b1, 1'b0, 1'b0);
        idle(3);

        $display("[TB] stalls with mid-frame mode change");
        ex = '{5, 7, 13, 15};
        runFrame4(ramp, ex, 1'b0, 1'b1, 1'b1);
        idle(3);

        $display("[TB] clear mid-frame");
        runPartial4();
        @(negedge clk);
        clear          = 1'b1;
        bus4.din_valid = 1'b1;
        bus4.din       = W'(100);
        bus4.mode      = 1'b0;
        afterEdge();
        checkOutput("clear busy", int'(bus4.busy), 0);
        checkOutput("clear dout", int'(bus4.dout), 0);
        checkOutput("clear dout_valid", int'(bus4.dout_valid), 0);
        ex = '{21, 23, 29, 31};
        runFrame4(ramp16, ex, 1'b0, 1'b0, 1'b0);
        idle(3);

        $display("[TB] asynchronous reset mid-frame");
        runPartial4();
        afterEdge();
        #1;
        rst            = 1'b0;
        bus4.din_valid = 1'b0;
        #1;
        checkOutput("async reset dout", int'(bus4.dout), 0);
        checkOutput("async reset dout_valid", int'(bus4.dout_valid), 0);
        checkOutput("async reset busy", int'(bus4.busy), 0);
        @(negedge clk);
        rst = 1'b1;
        runFrame4(ramp16, ex, 1'b0, 1'b0, 1'b0);
        idle(3);

        $display("[TB] 28x28 back-to-back frames");
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 28; r++) begin
                for (int c = 0; c < 28; c++) begin
                    s = W'($urandom);
                    pix28[r][c] = s;
                    @(negedge clk);
                    bus28.din       = s;
                    bus28.din_valid = 1'b1;
                    bus28.mode      = (f == 1);
                    if (r % 2 == 1 && c % 2 == 1) begin
                        wv = refWindow(pix28[r-1][c-1], pix28[r-1][c], pix28[r][c-1], pix28[r][c], f == 1);
                        e.value = wv;
                        e.fd    = (r == 27 && c == 27);
                        e.due   = $time + PERIOD;
                        q28.push_back(e);
                    end
                end
            end
        end
        @(negedge clk);
        bus28.din_valid = 1'b0;

        idle(5);
        checkOutput("dut4 queue drained", q4.size(), 0);
        checkOutput("dut28 queue drained", q28.size(), 0);
        checkOutput("dut4 frame_done count", fd4Count, 7);
        checkOutput("dut28 strobe count", strobe28Count, 392);
        checkOutput("dut28 frame_done count", fd28Count, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
